camera_frame_capture: RTL and testbench

//  Sits between camera_read's pixel stream and frame_buffer port A. Tracks x/y from pixel_valid,

---
 rtl/camera_pkg.sv | 18 +
 rtl/pixel_coord_counter.sv | 75 +++++++
 rtl/camera_frame_capture.sv | 136 +++++++++++++
 tb/tb_camera_frame_capture.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// rtl/camera_pkg.sv - shared types and pixel conversion for camera_frame_capture
package camera_pkg;

    localparam int RGB565_W = 16;
    localparam int RGB444_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_CAPTURE  = 2'd2
    } cap_state_t;

    // Keep the top four bits of each colour channel.
    function automatic logic [RGB444_W-1:0] rgb565_to_rgb444(input logic [RGB565_W-1:0] px);
        return {px[15:12], px[10:7], px[4:1]};
    endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// rtl/pixel_coord_counter.sv - x/y pixel position tracking, crop window test, optional frame check (FRAME_CHECK_EN)
module pixel_coord_counter #(
    parameter int SRC_W   = 640,
    parameter int SRC_H   = 480,
    parameter int CROP_X0 = 0,
    parameter int CROP_Y0 = 0,
    parameter int OUT_W   = 640,
    parameter int OUT_H   = 480
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pixel_valid,
    input  logic i_frame_done,
    output logic o_pixel_hit,
    output logic o_frame_err
);

    localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int YW = $clog2(SRC_H + 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    int            w_x;
    int            w_y;
    logic          w_line_end;
    logic          w_saturated;
    logic          w_in_window;

    assign w_x         = int'(r_x);
    assign w_y         = int'(r_y);
    assign w_line_end  = (w_x == SRC_W - 1);
    assign w_saturated = (w_y == SRC_H);
    assign w_in_window = (w_y >= CROP_Y0) && (w_y < CROP_Y0 + OUT_H) &&
                         (w_x >= CROP_X0) && (w_x < CROP_X0 + OUT_W);
    assign o_pixel_hit = i_pixel_valid && w_in_window;

    // Position advances per valid pixel; lines wrap on count, y holds at SRC_H once the frame is full.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_frame_done) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_pixel_valid && !w_saturated) begin
            if (w_line_end) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

`ifdef FRAME_CHECK_EN
    logic r_frame_err;
    logic w_frame_full;

    // A pixel arriving together with frame_done still counts toward the ending frame.
    assign w_frame_full = (w_saturated && (w_x == 0)) ||
                          (i_pixel_valid && (w_y == SRC_H - 1) && w_line_end);

    // Flag short/long frames at frame end, and any pixel beyond the last line.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= (i_frame_done && !w_frame_full) ||
                           (i_pixel_valid && w_saturated);
        end
    end

    assign o_frame_err = r_frame_err;
`else
    assign o_frame_err = 1'b0;
`endif

endmodule

// File: rtl/camera_frame_capture.sv
// rtl/camera_frame_capture.sv - frame-aligned crop/convert capture into frame buffer port A (option: FRAME_CHECK_EN)
module camera_frame_capture
    import camera_pkg::*;
#(
    parameter int SRC_W   = 640,
    parameter int SRC_H   = 480,
    parameter int CROP_X0 = 0,
    parameter int CROP_Y0 = 0,
    parameter int OUT_W   = 640,
    parameter int OUT_H   = 480,
    parameter int ADDR_W  = 19
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_capture_req,
    input  logic                i_mode_continuous,
    input  logic [RGB565_W-1:0] i_pixel_data,
    input  logic                i_pixel_valid,
    input  logic                i_frame_done,
    output logic                o_capture_busy,
    output logic                o_capture_done,
    output logic [7:0]          o_frames_captured,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [RGB444_W-1:0] o_mem_data,
    output logic                o_mem_we,
    output logic                o_frame_err
);

    localparam int TOTAL = OUT_W * OUT_H;

    cap_state_t            r_state;
    cap_state_t            w_next_state;
    logic                  w_done;
    logic                  w_frame_end;
    logic                  w_pixel_hit;
    logic                  w_write;
    logic [ADDR_W:0]       r_addr_cnt;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [RGB444_W-1:0]   r_mem_data;
    logic                  r_mem_we;
    logic                  r_capture_done;
    logic [7:0]            r_frames;

    pixel_coord_counter #(
        .SRC_W   (SRC_W),
        .SRC_H   (SRC_H),
        .CROP_X0 (CROP_X0),
        .CROP_Y0 (CROP_Y0),
        .OUT_W   (OUT_W),
        .OUT_H   (OUT_H)
    ) u_coord (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_pixel_valid (i_pixel_valid),
        .i_frame_done  (i_frame_done),
        .o_pixel_hit   (w_pixel_hit),
        .o_frame_err   (o_frame_err)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; capture only ever starts on a frame boundary.
    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_capture_req) begin
                    w_next_state = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (i_frame_done) begin
                    w_next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (i_frame_done) begin
                    w_frame_end = 1'b1;
                    if (!i_mode_continuous) begin
                        w_next_state = ST_IDLE;
                        w_done       = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // The bound on the address counter keeps a malformed frame from writing past the window.
    assign w_write = (r_state == ST_CAPTURE) && w_pixel_hit &&
                     (r_addr_cnt < (ADDR_W + 1)'(TOTAL));

    // Registered write port, running address and completion bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr_cnt     <= '0;
            r_mem_addr     <= '0;
            r_mem_data     <= '0;
            r_mem_we       <= 1'b0;
            r_capture_done <= 1'b0;
            r_frames       <= '0;
        end else begin
            r_mem_we       <= w_write;
            r_capture_done <= w_done;
            if (w_write) begin
                r_mem_addr <= r_addr_cnt[ADDR_W-1:0];
                r_mem_data <= rgb565_to_rgb444(i_pixel_data);
            end
            if (i_frame_done) begin
                r_addr_cnt <= '0;
            end else if (w_write) begin
                r_addr_cnt <= r_addr_cnt + 1'b1;
            end
            if (w_frame_end) begin
                r_frames <= r_frames + 1'b1;
            end
        end
    end

    assign o_capture_busy    = (r_state != ST_IDLE);
    assign o_capture_done    = r_capture_done;
    assign o_frames_captured = r_frames;
    assign o_mem_addr        = r_mem_addr;
    assign o_mem_data        = r_mem_data;
    assign o_mem_we          = r_mem_we;

endmodule

// File: tb/tb_camera_frame_capture.sv
// tb/tb_camera_frame_capture.sv - scoreboard bench for camera_frame_capture (full-window and cropped instances)
module tb_camera_frame_capture;

    typedef struct {
        int          addr;
        logic [11:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        capture_req;
    logic        mode_continuous;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        frame_done;

    logic        m_busy, m_done, m_we, m_err;
    logic [7:0]  m_frames;
    logic [4:0]  m_addr;
    logic [11:0] m_data;

    logic        c_busy, c_done, c_we, c_err;
    logic [7:0]  c_frames;
    logic [2:0]  c_addr;
    logic [11:0] c_data;

    exp_t q_main[$];
    exp_t q_crop[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_done_m = 0;
    int n_done_c = 0;
    int n_err_m  = 0;
    int n_err_c  = 0;

    logic [15:0] vec_d [3] = '{16'hF81F, 16'h07E0, 16'h0000};
    logic [11:0] vec_e [3] = '{12'hF0F, 12'h0F0, 12'h000};

    always #5 clk = ~clk;

    camera_frame_capture #(
        .SRC_W(8), .SRC_H(4), .CROP_X0(0), .CROP_Y0(0), .OUT_W(8), .OUT_H(4), .ADDR_W(5)
    ) u_main (
        .i_clk(clk), .i_reset(reset), .i_capture_req(capture_req),
        .i_mode_continuous(mode_continuous), .i_pixel_data(pixel_data),
        .i_pixel_valid(pixel_valid), .i_frame_done(frame_done),
        .o_capture_busy(m_busy), .o_capture_done(m_done), .o_frames_captured(m_frames),
        .o_mem_addr(m_addr), .o_mem_data(m_data), .o_mem_we(m_we), .o_frame_err(m_err)
    );

    camera_frame_capture #(
        .SRC_W(8), .SRC_H(4), .CROP_X0(2), .CROP_Y0(1), .OUT_W(4), .OUT_H(2), .ADDR_W(3)
    ) u_crop (
        .i_clk(clk), .i_reset(reset), .i_capture_req(capture_req),
        .i_mode_continuous(mode_continuous), .i_pixel_data(pixel_data),
        .i_pixel_valid(pixel_valid), .i_frame_done(frame_done),
        .o_capture_busy(c_busy), .o_capture_done(c_done), .o_frames_captured(c_frames),
        .o_mem_addr(c_addr), .o_mem_data(c_data), .o_mem_we(c_we), .o_frame_err(c_err)
    );

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every presented write is popped from its scoreboard and compared.
    always @(negedge clk) begin
        exp_t e;
        if (m_we === 1'b1) begin
            if (q_main.size() == 0) begin
                chk("main_unexpected_write_addr", int'(m_addr), -1);
            end else begin
                e = q_main.pop_front();
                chk("main_addr", int'(m_addr), e.addr);
                chk("main_data", int'(m_data), int'(e.data));
            end
        end
        if (c_we === 1'b1) begin
            if (q_crop.size() == 0) begin
                chk("crop_unexpected_write_addr", int'(c_addr), -1);
            end else begin
                e = q_crop.pop_front();
                chk("crop_addr", int'(c_addr), e.addr);
                chk("crop_data", int'(c_data), int'(e.data));
            end
        end
        if (m_done === 1'b1) n_done_m++;
        if (c_done === 1'b1) n_done_c++;
        if (m_err === 1'b1) n_err_m++;
        if (c_err === 1'b1) n_err_c++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_req();
        capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    // Drive n pixels in raster order; when capt is set, push the writes each instance should make.
    task automatic send_frame(input int n, input bit capt, input bit use_vec,
                              input bit last_with_fd, input bit do_fd);
        int          cidx = 0;
        logic [15:0] d;
        logic [11:0] e;
        for (int i = 0; i < n; i++) begin
            if (use_vec && i < 3) begin
                d = vec_d[i];
                e = vec_e[i];
            end else begin
                d = 16'(i * 16'h1357) ^ 16'hA5C3;
                e = {d[15:12], d[10:7], d[4:1]};
            end
            if (capt && i < 32) begin
                q_main.push_back('{i, e});
                if ((i % 8) >= 2 && (i % 8) <= 5 && (i / 8) >= 1 && (i / 8) <= 2) begin
                    q_crop.push_back('{cidx, e});
                    cidx++;
                end
            end
            pixel_data  = d;
            pixel_valid = 1'b1;
            frame_done  = (last_with_fd && do_fd && i == n - 1);
            tick();
            pixel_valid = 1'b0;
            frame_done  = 1'b0;
            if (i % 7 == 3) tick();
        end
        if (do_fd) begin
            if (!last_with_fd) pulse_fd();
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=%0d required=0", 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int done0;
        int err0;
        capture_req     = 1'b0;
        mode_continuous = 1'b0;
        pixel_data      = '0;
        pixel_valid     = 1'b0;
        frame_done      = 1'b0;
        do_reset();

        chk("reset_busy", int'(m_busy), 0);
        chk("reset_we", int'(m_we), 0);
        chk("reset_addr", int'(m_addr), 0);
        chk("reset_data", int'(m_data), 0);
        chk("reset_frames", int'(m_frames), 0);
        chk("reset_done", int'(m_done), 0);

        // Single shot with known colour vectors; second request while busy is ignored.
        pulse_req();
        chk("busy_wait_sof", int'(m_busy), 1);
        pulse_fd();
        pulse_req();
        send_frame(32, 1, 1, 0, 1);
        chk("t1_done_main", n_done_m, 1);
        chk("t1_done_crop", n_done_c, 1);
        chk("t1_frames", int'(m_frames), 1);
        chk("t1_busy_after", int'(m_busy), 0);
        chk("t1_q_main_empty", q_main.size(), 0);
        chk("t1_q_crop_empty", q_crop.size(), 0);
        send_frame(32, 0, 0, 0, 1);
        chk("t1_idle_frames", int'(m_frames), 1);

        // Continuous over three frames, one with a pixel coincident with frame_done.
        do_reset();
        done0 = n_done_m;
        mode_continuous = 1'b1;
        pulse_req();
        pulse_fd();
        for (int f = 0; f < 3; f++) send_frame(32, 1, 0, (f == 1), 1);
        chk("t4_frames_3", int'(m_frames), 3);
        chk("t4_no_done", n_done_m - done0, 0);
        chk("t4_busy", int'(m_busy), 1);
        mode_continuous = 1'b0;
        send_frame(32, 1, 0, 0, 1);
        chk("t4_frames_4", int'(m_frames), 4);
        chk("t4_done", n_done_m - done0, 1);
        chk("t4_crop_frames", int'(c_frames), 4);
        chk("t4_q_main_empty", q_main.size(), 0);

        // Reset in the middle of a capture.
        do_reset();
        pulse_req();
        pulse_fd();
        send_frame(10, 1, 0, 0, 0);
        do_reset();
        chk("t5_we_after_reset", int'(m_we), 0);
        chk("t5_busy_after_reset", int'(m_busy), 0);
        chk("t5_q_main_drained", q_main.size(), 0);
        done0 = n_done_m;
        pulse_req();
        send_frame(22, 0, 0, 0, 1);
        send_frame(32, 1, 0, 0, 1);
        chk("t5_done", n_done_m - done0, 1);
        chk("t5_frames", int'(m_frames), 1);
        chk("t5_q_crop_empty", q_crop.size(), 0);

`ifdef FRAME_CHECK_EN
        // Frame length checking: short frame, good frame, over-long frame.
        do_reset();
        pulse_fd();
        tick();
        err0 = n_err_m;
        send_frame(31, 0, 0, 0, 1);
        chk("t6_short_err", n_err_m - err0, 1);
        err0 = n_err_m;
        send_frame(32, 0, 0, 1, 1);
        chk("t6_good_no_err", n_err_m - err0, 0);
        err0 = n_err_m;
        send_frame(33, 0, 0, 0, 1);
        chk("t6_long_err", n_err_m - err0, 1);
        chk("t6_crop_err_match", n_err_c, n_err_m);
`else
        err0 = n_err_m + n_err_c;
        chk("frame_err_absent", err0, 0);
`endif

        tick();
        chk("final_q_main", q_main.size(), 0);
        chk("final_q_crop", q_crop.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
